alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle controller in front of the Execute-stage ALU, which has a fixed 1-bit shift amount.
//  Accepts one operation per valid/ready handshake and drives the ALU control and operand inputs.
//  Single-cycle ops pass through in one ALU cycle.
//  Variable shifts are performed by iterating the 1-bit ALU shift shamt times.
//  The result is returned on a valid/ready output handshake to the pipeline/writeback side.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width
//  SHAMT_WIDTH  5   shift-amount width (max shift 2^SHAMT_WIDTH-1)
//  CTRL_WIDTH   4   ALU control code width
// PORTS
//  clock        in   1           single clock, all state on rising edge
//  resetN       in   1           asynchronous, active-low reset
//  inValid      in   1           request valid
//  inReady      out  1           sequencer can accept (high only in IDLE)
//  inOpCode     in   CTRL_WIDTH  ALU control code of the operation
//  inShamt      in   SHAMT_WIDTH shift count (shift codes only)
//  inOperandA   in   DATA_WIDTH  first operand
//  inOperandB   in   DATA_WIDTH  second operand (ignored for shifts)
//  outValid     out  1           result valid (high only in DONE)
//  outReady     in   1           consumer accepts result
//  outResult    out  DATA_WIDTH  final result
//  outZero      out  1           outResult == 0
//  aluInputOne  out  DATA_WIDTH  to ALU inputOne
//  aluInputTwo  out  DATA_WIDTH  to ALU inputTwo
//  aluControl   out  CTRL_WIDTH  to ALU ALUControl
//  aluResult    in   DATA_WIDTH  from ALU result (combinational)
//  aluZero      in   1           from ALU zero
//  busy         out  1           state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, inReady=1, outValid=0, outResult=0, outZero=0, aluControl=ADD, alu inputs=0, busy=0.
//  States: IDLE -> EXEC | DONE; EXEC -> EXEC | DONE; DONE -> IDLE.
//  IDLE: on inValid&&inReady, latch op, shamt, A->acc, B. Next state:
//    shift code with shamt==0 -> DONE, result=A, zero=(A==0).
//    otherwise -> EXEC with count=shamt (shift) or 1 (non-shift).
//  EXEC: aluInputOne=acc, aluInputTwo=B (0 for shifts), aluControl=op.
//    Each edge: acc<=aluResult, zeroReg<=aluZero, count--.
//    When count reaches 0, go to DONE.
//  DONE: outValid=1; outResult/outZero held stable until outReady; on outReady -> IDLE.
//  Latency, accept edge to outValid: shamt==0 shift = 1 cycle; non-shift = 2; shift k = k+1.
//  Back-pressure: outValid held indefinitely; no new accept until the return to IDLE.
//  Opcodes: shift set {SLL,SRL,SRA} iterates; every other code is a single ALU cycle, passed unchanged.
//  Max shift 31: 31 EXEC cycles, no wrap; count is SHAMT_WIDTH bits, decremented only while >0.
//  inValid while busy is ignored; inputs are sampled only on the accept edge.
//  Async reset mid-EXEC or mid-DONE: op dropped, outputs to reset values immediately.
//  aluInputOne/Two/aluControl are registered-state driven; outside EXEC they are 0/0/ADD.
// CONFIGURATION
//  ALU_SEQ_ZERO_SKIP_EN defined:
//    In EXEC for SLL/SRL, if acc==0, go to DONE next edge with result 0, zero=1.
//    SRA is also eligible (0 stays 0).
//    Latency becomes min(k+1, cycles to zero +1).
//  Undefined: always exactly shamt iterations.
// STRUCTURE
//  Shared package alu_defs: ALU control code constants (AND=0000, OR=0001, ADD=0010,
//    SUB=0110, SLT=0111, SLL=1000, SRL=1001, SRA=1010).
//  Package also holds the state encoding (IDLE/EXEC/DONE) and the is_shift(code) function.
//  No sub-module; the ALU stays external and is shared with the Execute datapath via the alu* ports.
// TESTING
//  ADD A=5 B=7: outValid 2 cycles after accept, outResult=12, outZero=0.
//  SUB A=9 B=9: outResult=0, outZero=1.
//  SLL A=1 shamt=31: 31 EXEC cycles, outResult=0x80000000.
//  SRA A=0x80000000 shamt=4: outResult=0xF8000000.
//  SLL shamt=0 A=0x1234: outValid 1 cycle after accept, result 0x1234.
//  Hold outReady=0 for 5 cycles: outValid/outResult stable, inReady=0.
//  Deassert resetN mid-shift: outValid=0, state IDLE, next op correct.
//  ZERO_SKIP_EN, SRL A=0x10 shamt=20: done after 5 EXEC cycles, result 0, outZero=1.
//  Without ZERO_SKIP_EN, same case: 20 EXEC cycles.

Source files
------------

// File: rtl/alu_defs.sv
// alu_defs: ALU control codes, sequencer state encoding and opcode helpers
// shared between the Execute-stage ALU and its multi-cycle sequencer.
package alu_defs;

    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b1001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    // Shift codes are the only ones iterated; the ALU shifts by exactly one bit.
    function automatic logic is_shift(input logic [ALU_CTRL_W-1:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle front end for the 1-bit-shift Execute ALU.
// Optional build macro ALU_SEQ_ZERO_SKIP_EN ends a shift early once the accumulator is zero.
module alu_sequencer
    import alu_defs::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int CTRL_WIDTH  = 4
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [CTRL_WIDTH-1:0]  inOpCode,
    input  logic [SHAMT_WIDTH-1:0] inShamt,
    input  logic [DATA_WIDTH-1:0]  inOperandA,
    input  logic [DATA_WIDTH-1:0]  inOperandB,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [DATA_WIDTH-1:0]  outResult,
    output logic                   outZero,
    output logic [DATA_WIDTH-1:0]  aluInputOne,
    output logic [DATA_WIDTH-1:0]  aluInputTwo,
    output logic [CTRL_WIDTH-1:0]  aluControl,
    input  logic [DATA_WIDTH-1:0]  aluResult,
    input  logic                   aluZero,
    output logic                   busy
);

    seq_state_e             state_r;
    logic [SHAMT_WIDTH-1:0] count_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [DATA_WIDTH-1:0]  out_result_r;
    logic                   out_zero_r;
    logic [DATA_WIDTH-1:0]  alu_one_r;
    logic [DATA_WIDTH-1:0]  alu_two_r;
    logic [CTRL_WIDTH-1:0]  alu_ctrl_r;
    logic                   busy_r;

    logic                   accept_s;
    logic                   in_shift_s;
    logic                   exec_last_s;
    logic                   exec_skip_s;
    logic                   exec_end_s;

    // Per-cycle decisions feeding the state register.
    always_comb begin
        accept_s    = inValid && in_ready_r;
        in_shift_s  = is_shift(ALU_CTRL_W'(inOpCode));
        exec_last_s = (count_r == SHAMT_WIDTH'(1'b1));
`ifdef ALU_SEQ_ZERO_SKIP_EN
        // A shift of zero stays zero, so the remaining iterations cannot change the result.
        exec_skip_s = is_shift(ALU_CTRL_W'(alu_ctrl_r)) && (aluResult == {DATA_WIDTH{1'b0}});
`else
        exec_skip_s = 1'b0;
`endif
        exec_end_s  = exec_last_s || exec_skip_s;
    end

    // Sequencer state plus every registered output; the accumulator is the ALU operand register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r      <= ST_IDLE;
            count_r      <= {SHAMT_WIDTH{1'b0}};
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_result_r <= {DATA_WIDTH{1'b0}};
            out_zero_r   <= 1'b0;
            alu_one_r    <= {DATA_WIDTH{1'b0}};
            alu_two_r    <= {DATA_WIDTH{1'b0}};
            alu_ctrl_r   <= CTRL_WIDTH'(ALU_ADD);
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (in_shift_s && (inShamt == {SHAMT_WIDTH{1'b0}})) begin
                            state_r      <= ST_DONE;
                            out_valid_r  <= 1'b1;
                            out_result_r <= inOperandA;
                            out_zero_r   <= (inOperandA == {DATA_WIDTH{1'b0}});
                        end else begin
                            state_r    <= ST_EXEC;
                            count_r    <= in_shift_s ? inShamt : SHAMT_WIDTH'(1'b1);
                            alu_one_r  <= inOperandA;
                            alu_two_r  <= in_shift_s ? {DATA_WIDTH{1'b0}} : inOperandB;
                            alu_ctrl_r <= inOpCode;
                        end
                    end
                end
                ST_EXEC: begin
                    if (count_r != {SHAMT_WIDTH{1'b0}}) begin
                        count_r <= count_r - SHAMT_WIDTH'(1'b1);
                    end
                    if (exec_end_s) begin
                        state_r      <= ST_DONE;
                        out_valid_r  <= 1'b1;
                        out_result_r <= aluResult;
                        out_zero_r   <= aluZero || exec_skip_s;
                        alu_one_r    <= {DATA_WIDTH{1'b0}};
                        alu_two_r    <= {DATA_WIDTH{1'b0}};
                        alu_ctrl_r   <= CTRL_WIDTH'(ALU_ADD);
                    end else begin
                        alu_one_r <= aluResult;
                    end
                end
                ST_DONE: begin
                    if (outReady) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    count_r     <= {SHAMT_WIDTH{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    alu_one_r   <= {DATA_WIDTH{1'b0}};
                    alu_two_r   <= {DATA_WIDTH{1'b0}};
                    alu_ctrl_r  <= CTRL_WIDTH'(ALU_ADD);
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign inReady     = in_ready_r;
    assign outValid    = out_valid_r;
    assign outResult   = out_result_r;
    assign outZero     = out_zero_r;
    assign aluInputOne = alu_one_r;
    assign aluInputTwo = alu_two_r;
    assign aluControl  = alu_ctrl_r;
    assign busy        = busy_r;

endmodule
